// File: rtl/mbt_pixel_reader_if.sv
// Frame-buffer port-B read bus between the pixel reader (master) and the
// dual-port frame buffer (slave); read data returns two cycles after the request.
interface mbt_pixel_reader_if;
    logic [16:0] addrb;
    logic        enb;
    logic [31:0] doutb;

    modport master (output addrb, output enb, input doutb);
    modport slave  (input addrb, input enb, output doutb);
endinterface

// File: rtl/mbt_pixel_reader.sv
// Pixel reader: walks VGA raster timing, fetches packed iteration counts from
// frame-buffer port B and maps them to 12-bit colour three cycles behind the counter.
module mbt_pixel_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int MAX_ITER = 127
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                engine_ready,
    mbt_pixel_reader_if.master  fb,
    output logic                hsync,
    output logic                vsync,
    output logic [11:0]         rgb,
    output logic                frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Per-pixel attributes carried alongside the 2-cycle frame-buffer read.
    typedef struct packed {
        logic       show;
        logic [1:0] lane;
        logic       hs_n;
        logic       vs_n;
        logic       fs;
    } tap_t;

    localparam tap_t TAP_RESET = '{show: 1'b0, lane: 2'b00, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic          active_c;
    logic          frame_top;
    logic          display_en;
    logic [16:0]   addr_calc;
    logic [16:0]   addr_hold;
    tap_t          stage_c;
    tap_t          s1;
    tap_t          s2;
    logic [6:0]    count;
    logic [11:0]   rgb_c;

    assign h_last    = (h == HW'(H_TOTAL - 1));
    assign v_last    = (v == VW'(V_TOTAL - 1));
    assign active_c  = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign frame_top = (h == '0) && (v == '0);
    assign addr_calc = 17'(v) * 17'(H_ACTIVE / 4) + 17'(h >> 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // NOTE: enb is gated by rst so no read is issued while reset is held;
    // the counter sits at (0,0), which would otherwise look like an active pixel.
    assign fb.enb   = active_c && rst;
    assign fb.addrb = fb.enb ? addr_calc : addr_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_hold  <= '0;
            display_en <= 1'b0;
        end else begin
            if (active_c)
                addr_hold <= addr_calc;
            if (engine_ready && frame_top)
                display_en <= 1'b1;
        end
    end

    // NOTE: every field gets a default first so this block can never infer a latch.
    always_comb begin
        stage_c      = TAP_RESET;
        stage_c.show = active_c && (display_en || (engine_ready && frame_top));
        stage_c.lane = h[1:0];
        stage_c.hs_n = !((int'(h) >= HS_START) && (int'(h) < HS_END));
        stage_c.vs_n = !((int'(v) >= VS_START) && (int'(v) < VS_END));
        stage_c.fs   = frame_top;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= TAP_RESET;
            s2 <= TAP_RESET;
        end else begin
            s1 <= stage_c;
            s2 <= s1;
        end
    end

    // Bit 7 of each byte lane is spare and never reaches the palette.
    assign count = fb.doutb[{s2.lane, 3'b000} +: 7];

    always_comb begin
        rgb_c = '0;
        if (s2.show && (int'(count) < MAX_ITER))
            rgb_c = {count[6:3], count[4:1], count[2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            rgb         <= rgb_c;
            hsync       <= s2.hs_n;
            vsync       <= s2.vs_n;
            frame_start <= s2.fs;
        end
    end

endmodule

// File: tb/tb_mbt_pixel_reader.sv
// Bench for mbt_pixel_reader: a reduced-timing instance checked cycle by cycle
// against a raster/frame model, plus a default-timing instance for absolute values.
`timescale 1ns/1ps
module tb_mbt_pixel_reader;

    // Reduced raster so several whole frames fit in a short run.
    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int MAXI = 127;
    localparam int WORDS = VA * HA / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        engine_ready = 1'b0;
    logic        full_ready = 1'b0;
    logic        hsync, vsync, frame_start;
    logic [11:0] rgb;
    logic        f_hsync, f_vsync, f_fs;
    logic [11:0] f_rgb;

    mbt_pixel_reader_if fb ();
    mbt_pixel_reader_if fb_full ();

    mbt_pixel_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .MAX_ITER(MAXI)
    ) dut (
        .clk(clk), .rst(rst), .engine_ready(engine_ready), .fb(fb),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
    );

    mbt_pixel_reader dut_full (
        .clk(clk), .rst(rst), .engine_ready(full_ready), .fb(fb_full),
        .hsync(f_hsync), .vsync(f_vsync), .rgb(f_rgb), .frame_start(f_fs)
    );

    always #5 clk = ~clk;

    // Frame buffer: 2-cycle read latency on port B.
    logic [31:0] mem [WORDS];
    logic [16:0] rd_a;
    logic        rd_v = 1'b0;
    always @(posedge clk) begin
        rd_a <= fb.addrb;
        rd_v <= fb.enb;
        if (rd_v && int'(rd_a) < WORDS)
            fb.doutb <= mem[int'(rd_a)];
    end
    assign fb_full.doutb = '0;

    int nvec = 0;
    int nfail = 0;
    int run_no = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit act(int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    function automatic int addr_of(int p);
        return ((p / HT) % VT) * (HA / 4) + (p % HT) / 4;
    endfunction

    function automatic logic [11:0] pal(int c);
        int r, g, b;
        if (c >= MAXI) return 12'h000;
        r = c / 8;
        g = (c / 2) % 16;
        b = (c % 8) * 2 + 1;
        return 12'(r * 256 + g * 16 + b);
    endfunction

    // Model state: idx = counter position since the last reset edge.
    int idx = 0;
    int last_addr = 0;
    int en_frame = -1;
    bit started = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            idx       <= 0;
            last_addr <= 0;
            en_frame  <= -1;
            started   <= 1'b1;
        end else begin
            if (act(idx)) last_addr <= addr_of(idx);
            if ((idx % FT == 0) && engine_ready && en_frame < 0) en_frame <= idx / FT;
            idx <= idx + 1;
        end
    end

    logic [11:0] lit [4] = '{12'h001, 12'h017, 12'h281, 12'h000};

    int   tick = 0;
    int   hs_fall = -1, vs_fall = -1, fs_last = -1;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    always @(negedge clk) begin
        int q, qh, qv, f, c;
        logic [11:0] e_rgb;
        logic e_hs, e_vs, e_fs, e_en;
        logic [31:0] w;
        if (started) begin
            tick++;
            e_en = rst && act(idx);
            check($sformatf("enb@%0d", idx), fb.enb, e_en);
            check($sformatf("addrb@%0d", idx), fb.addrb, e_en ? addr_of(idx) : last_addr);

            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
            if (idx >= 3) begin
                q  = idx - 3;
                qh = q % HT;
                qv = (q / HT) % VT;
                f  = q / FT;
                e_hs = !(qh >= HA + HF && qh < HA + HF + HS);
                e_vs = !(qv >= VA + VF && qv < VA + VF + VS);
                e_fs = (q % FT == 0);
                if (qh < HA && qv < VA && en_frame >= 0 && f >= en_frame) begin
                    w = mem[qv * (HA / 4) + qh / 4];
                    c = int'((w >> (8 * (qh % 4))) & 32'h7F);
                    e_rgb = pal(c);
                    if (qv == 0 && qh < 4)
                        check($sformatf("lane_pal%0d", qh), rgb, lit[qh]);
                end
            end
            check($sformatf("pixel@%0d", idx), {rgb, hsync, vsync, frame_start},
                  {e_rgb, e_hs, e_vs, e_fs});

            // Pulse widths and periods on the reduced raster.
            if (!rst) begin
                hs_fall = -1; vs_fall = -1; fs_last = -1;
            end else begin
                if (hs_prev && !hsync) begin
                    if (hs_fall >= 0) check("hs_period", tick - hs_fall, HT);
                    hs_fall = tick;
                end
                if (!hs_prev && hsync && hs_fall >= 0) check("hs_width", tick - hs_fall, HS);
                if (vs_prev && !vsync) begin
                    if (vs_fall >= 0) check("vs_period", tick - vs_fall, FT);
                    vs_fall = tick;
                end
                if (!vs_prev && vsync && vs_fall >= 0) check("vs_width", tick - vs_fall, VS * HT);
                if (frame_start) begin
                    if (fs_last >= 0) check("fs_period", tick - fs_last, FT);
                    fs_last = tick;
                end
            end
            hs_prev = hsync;
            vs_prev = vsync;

            // Default-timing instance: absolute addresses and sync position.
            if (run_no == 0) begin
                check("full_rgb", f_rgb, 12'h000);
                if (idx == 2 * 800 + 5) begin
                    check("full_addr_5_2", fb_full.addrb, 321);
                    check("full_enb_5_2", fb_full.enb, 1);
                end
                if (idx == 2 * 800 + 640) begin
                    check("full_enb_640_2", fb_full.enb, 0);
                    check("full_addr_hold", fb_full.addrb, 479);
                end
                if (idx == 3 + 655) check("full_hs_655", f_hsync, 1);
                if (idx == 3 + 656) check("full_hs_656", f_hsync, 0);
                if (idx == 3 + 751) check("full_hs_751", f_hsync, 0);
                if (idx == 3 + 752) check("full_hs_752", f_hsync, 1);
                if (idx == 3) check("full_fs", f_fs, 1);
            end
        end
    end

    task automatic wait_idx(int target);
        int budget = 20000;
        while (idx != target && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("wait_idx", idx, target);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h7F10_0300;
        mem[WORDS - 1][31:24] = 8'hFF;

        rst = 1'b0;
        engine_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Mid-frame enable only takes hold at the next frame start.
        wait_idx(FT / 2 + int'($urandom_range(0, HT - 1)));
        engine_ready = 1'b1;
        wait_idx(2 * FT + FT / 3);
        engine_ready = 1'b0;

        // Reset in the middle of an active line of frame 4.
        wait_idx(4 * FT + 4 * HT + 20);
        rst = 1'b0;
        @(posedge clk);
        #1 run_no = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Enable cleared by reset; re-arm just before the next frame.
        wait_idx(FT - 5);
        engine_ready = 1'b1;
        wait_idx(3 * FT);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mbt_pixel_reader.md
MBT_PIXEL_READER -- requirements
Module: mbt_pixel_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porches and sync width; line total 800.
REQ-003 SHALL have parameter V_ACTIVE, default 480, and V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical timing; frame total 525.
REQ-004 SHALL have parameter MAX_ITER, default 127: iteration count treated as "inside set".
REQ-005 SHALL have port clk, input, 1: pixel clock; single clock domain.
REQ-006 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port engine_ready, input, 1: engine has completed a full frame buffer.
REQ-008 SHALL have port addrb, output, 17: frame-buffer port-B word address.
REQ-009 SHALL have port enb, output, 1: port-B read enable.
REQ-010 SHALL have port doutb, input, 32: port-B read data; fixed 2-cycle latency from addrb/enb.
REQ-011 SHALL have ports hsync and vsync, output, 1 each: active-low sync.
REQ-012 SHALL have port rgb, output, 12: {R[3:0],G[3:0],B[3:0]}.
REQ-013 SHALL have port frame_start, output, 1: one-cycle pulse aligned with output pixel (0,0).

Function
REQ-014 SHALL keep counter h (0..799) and counter v (0..524); h increments each cycle; at h=799 wrap to 0 and increment v; at v=524 with h=799 wrap both to 0.
REQ-015 SHALL define active = (h<640)&&(v<480) at counter stage.
REQ-016 SHALL, when active, drive enb=1 and addrb = v*160 + h[9:2] at counter stage; when not active, enb=0 and addrb holds its last value.
REQ-017 SHALL delay active, lane=h[1:0], hsync_raw and vsync_raw by 2 cycles to align with doutb.
REQ-018 SHALL select the pixel count as doutb[8*lane+6 : 8*lane]; bit 8*lane+7 is ignored.
REQ-019 SHALL map count c: if c>=MAX_ITER then rgb=12'h000, else R=c[6:3], G=c[4:1], B={c[2:0],1'b1}.
REQ-020 SHALL register the palette output; total latency from counter (h,v) to the rgb/hsync/vsync/frame_start for that pixel is exactly 3 cycles.
REQ-021 SHALL drive hsync=0 iff delayed h is in [656,751], and vsync=0 iff delayed v is in [490,491].
REQ-022 SHALL force rgb=12'h000 for blanking pixels (delayed active=0).
REQ-023 SHALL keep a display_en flag: set only when engine_ready=1 is sampled at counter (0,0); once set, it stays set until reset.
REQ-024 SHALL force rgb=12'h000 while display_en=0; a mid-frame engine_ready rise takes effect at the next frame start.
REQ-025 SHALL pulse frame_start for exactly one cycle when the delayed counter equals (0,0).

Reset
REQ-026 SHALL, on a clk edge with rst=0, clear h, v, display_en, and all pipeline registers.
REQ-027 SHALL drive these outputs in the cycle after the reset edge: hsync=1, vsync=1, rgb=0, enb=0, addrb=0, frame_start=0.
REQ-028 SHALL, after reset is released mid-line, start counting from (0,0); frame_start occurs 3 cycles after release.

Verification
REQ-029 SHALL check timing: after reset release, count hsync low pulses of 96 cycles with an 800-cycle period, and vsync low pulses of 2 lines with a 420000-cycle period.
REQ-030 SHALL check addressing: counter (5,2) -> addrb=321 with enb=1; counter (640,2) -> enb=0.
REQ-031 SHALL check lane select and palette: doutb=32'h7F_10_03_00 returned for word 0 with display_en=1 -> pixels 0..3 give rgb 12'h001, 12'h017, 12'h281, 12'h000.
REQ-032 SHALL check gating: engine_ready rises at counter (100,200) -> rgb stays 0 until the next frame, then data appears from output pixel (0,0).
REQ-033 SHALL check boundaries: the wrap from (799,524) to (0,0) produces frame_start exactly once per 420000 cycles, and rgb=0 at output h=640..799.
REQ-034 SHALL check mid-frame reset: rst=0 at counter (300,250) -> the next cycle shows the reset values, and the counter restarts at (0,0) after release.
